leaf_out_arbiter: RTL and testbench
===================================

# leaf_out_arbiter

Parametrised output-side packetiser for a leaf shell. It merges NUM_OUT_PORTS user streams (valid/ack) into one BFT packet stream using round-robin arbitration. Each stream has per-port credit (destination free-space) and a per-port write-address counter. It sits between the user kernel's output ports and the leaf-to-BFT output, and generalises the fixed 3-output leaf to any port count with credit-based flow control and resend suppression.

## Interface
Parameters:
- PACKET_BITS, 49, packet width; must equal 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS
- PAYLOAD_BITS, 32, user data width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, write-address field width
- NUM_OUT_PORTS, 3, number of user output streams (1..2^NUM_PORT_BITS)
- NUM_BRAM_ADDR_BITS, 7, log2 of destination buffer depth; initial credit = 2^NUM_BRAM_ADDR_BITS
- FREESPACE_UPDATE_SIZE, 64, credit returned per update event

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  packed payloads, port i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
- vld_user2interface  in  NUM_OUT_PORTS  per-port valid
- ack_interface2user  out  NUM_OUT_PORTS  per-port accept (one-hot or zero)
- dest_cfg  in  NUM_OUT_PORTS*(NUM_LEAF_BITS+NUM_PORT_BITS)  per-port {dest_leaf, dest_port}; quasi-static
- credit_upd_vld  in  1  credit return strobe
- credit_upd_port  in  NUM_PORT_BITS  port index receiving the credit
- resend  in  1  suppress output and freeze all state
- dout_leaf_interface2bft  out  PACKET_BITS  registered packet
- credit_overflow  out  1  sticky error flag

## Operation
- Packet layout: [PACKET_BITS-1]=valid, then dest_leaf, dest_port, addr, payload[PAYLOAD_BITS-1:0] (MSB to LSB).
- Per-port credit counter, width NUM_BRAM_ADDR_BITS+1, reset to 2^NUM_BRAM_ADDR_BITS.
- Port i is eligible when vld[i]=1, credit[i]>0, and resend=0.
- Round-robin: pointer holds the last granted port and resets to NUM_OUT_PORTS-1, so port 0 wins first. The search starts at pointer+1 modulo NUM_OUT_PORTS. The first eligible port is granted and the pointer moves to it. With no eligible port the pointer holds.
- ack[i] is combinational and equals grant[i]. A transfer occurs when vld[i]&ack[i]. At most one ack is high per cycle.
- On a transfer:
  - the output register loads {1, dest_cfg[i], addr[i], data[i]};
  - addr[i] increments, wrapping 2^NUM_ADDR_BITS-1 -> 0;
  - credit[i] decrements.
- With no transfer, the output register loads all zeros.
- Credit update: if credit_upd_vld and credit_upd_port<NUM_OUT_PORTS, credit[port] += FREESPACE_UPDATE_SIZE.
  - Same-cycle send on the same port gives a net change of +FREESPACE_UPDATE_SIZE-1.
  - If the result would exceed 2^NUM_BRAM_ADDR_BITS, credit saturates at 2^NUM_BRAM_ADDR_BITS and credit_overflow sets.
  - credit_upd_port>=NUM_OUT_PORTS is ignored and sets credit_overflow.
- Credit updates are applied even while resend=1.
- resend=1:
  - ack forced to 0;
  - output register loads zero;
  - pointer and addr counters hold.
- credit_overflow clears only on reset.
- Reset mid-operation: all state returns to reset values immediately, and any in-flight registered packet is discarded.

## Timing
- Reset values: dout_leaf_interface2bft=0, ack=0, credit_overflow=0, all addr=0, all credit=2^NUM_BRAM_ADDR_BITS, pointer=NUM_OUT_PORTS-1.
- Latency: an accepted word appears on dout one cycle after the vld&ack edge.
- Throughput: one packet per cycle aggregate.
- A port with credit 0 is not acked. A credit update in cycle t makes the port eligible in cycle t+1.
- resend asserted in cycle t gives dout=0 from cycle t+1. Deasserting it resumes arbitration the same cycle.

## Test plan
- Reset: hold reset_n=0 with all inputs active -> dout=0, ack=0, credit_overflow=0. After release, first grant goes to port 0 when all vld=1.
- Round-robin: vld=3'b111 for 6 cycles with default params -> grant order 0,1,2,0,1,2. Packets carry addr 0,0,0,1,1,1 and per-port dest_cfg fields.
- Credit exhaustion/wrap: port 1 alone streams 200 words, no updates:
  - exactly 128 acks, then ack stays 0;
  - addr field runs 0..127.
  - One credit update then yields 64 more acks, addr 0..63 after wrap.
- Simultaneous send and update: port 0 at credit 10 sends while credit_upd_port=0 pulses -> credit 73. No overflow.
- Overflow: update port 2 at full credit -> credit stays 128, credit_overflow=1 sticky. Update with credit_upd_port=5 -> credit_overflow=1.
- Resend: assert for 4 cycles mid-stream -> ack=0, dout=0 from the next cycle. Stream resumes with the next addr in sequence and round-robin order preserved.

Source files
------------

// File: rtl/leaf_out_arbiter.sv
// ----------------------------------------------------------------------------
// leaf_out_arbiter
//
// Output-side packetiser for a leaf shell. It merges NUM_OUT_PORTS user
// valid/ack streams into one BFT packet stream using round-robin arbitration.
// Each port keeps a destination credit counter (free space at the receiver)
// and a write-address counter that is stamped into every packet it sends.
//
// Ports:
//   clk                       - single clock, rising edge
//   reset_n                   - asynchronous active-low reset
//   din_leaf_user2interface   - packed per-port payloads, port i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   vld_user2interface        - per-port valid
//   ack_interface2user        - per-port accept (one-hot or zero), combinational
//   dest_cfg                  - per-port {dest_leaf, dest_port}, quasi-static
//   credit_upd_vld            - credit return strobe
//   credit_upd_port           - port index receiving FREESPACE_UPDATE_SIZE credit
//   resend                    - suppresses output and freezes pointer/address state
//   dout_leaf_interface2bft   - registered packet {valid, leaf, port, addr, payload}
//   credit_overflow           - sticky error flag, cleared only by reset
// ----------------------------------------------------------------------------
module leaf_out_arbiter #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_OUT_PORTS         = 3,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]           din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                        vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                        ack_interface2user,
    input  logic [NUM_OUT_PORTS*(NUM_LEAF_BITS+NUM_PORT_BITS)-1:0] dest_cfg,
    input  logic                                            credit_upd_vld,
    input  logic [NUM_PORT_BITS-1:0]                        credit_upd_port,
    input  logic                                            resend,
    output logic [PACKET_BITS-1:0]                          dout_leaf_interface2bft,
    output logic                                            credit_overflow
);

    localparam int CW         = NUM_BRAM_ADDR_BITS + 1;
    localparam int DCW        = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int CREDIT_MAX = 1 << NUM_BRAM_ADDR_BITS;

    // Architectural state
    logic [CW-1:0]            credit_r [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] addr_r   [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] ptr_r;
    logic [PACKET_BITS-1:0]   dout_r;
    logic                     credit_overflow_r;

    // Combinational decisions
    logic [NUM_OUT_PORTS-1:0] eligible_s;
    logic [NUM_OUT_PORTS-1:0] grant_s;
    logic [NUM_PORT_BITS-1:0] grant_idx_s;
    logic                     found_s;
    int                       cand_s;
    logic [PACKET_BITS-1:0]   pkt_nxt_s;
    logic [CW-1:0]            credit_nxt_s [NUM_OUT_PORTS];
    logic [NUM_OUT_PORTS-1:0] sat_hit_s;
    logic [31:0]              credit_sum_s [NUM_OUT_PORTS];
    logic                     bad_port_s;

    assign ack_interface2user      = grant_s;
    assign dout_leaf_interface2bft = dout_r;
    assign credit_overflow         = credit_overflow_r;

    // Eligibility: valid, non-zero credit, not resending; reset_n gates it so ack is 0 during reset
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            eligible_s[i] = vld_user2interface[i] && (credit_r[i] != '0) && !resend && reset_n;
        end
    end

    // Round-robin search starting one past the last granted port
    always_comb begin
        grant_s     = '0;
        grant_idx_s = ptr_r;
        found_s     = 1'b0;
        cand_s      = 0;
        for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
            cand_s = (int'(ptr_r) + k) % NUM_OUT_PORTS;
            if (!found_s && eligible_s[cand_s]) begin
                grant_s[cand_s] = 1'b1;
                grant_idx_s     = NUM_PORT_BITS'(cand_s);
                found_s         = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next output packet: granted port's fields, or all zeros when idle
    always_comb begin
        pkt_nxt_s = '0;
        if (found_s) begin
            pkt_nxt_s = {1'b1,
                         dest_cfg[int'(grant_idx_s)*DCW +: DCW],
                         addr_r[grant_idx_s],
                         din_leaf_user2interface[int'(grant_idx_s)*PAYLOAD_BITS +: PAYLOAD_BITS]};
        end else begin
            pkt_nxt_s = '0;
        end
    end

    // Credit next-state: add returned space, subtract a send, saturate at buffer depth
    always_comb begin
        bad_port_s = credit_upd_vld && (int'(credit_upd_port) >= NUM_OUT_PORTS);
        sat_hit_s  = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_sum_s[i] = 32'(credit_r[i])
                            + ((credit_upd_vld && (int'(credit_upd_port) == i)) ? 32'(FREESPACE_UPDATE_SIZE) : 32'd0)
                            - (grant_s[i] ? 32'd1 : 32'd0);
            if (credit_sum_s[i] > 32'(CREDIT_MAX)) begin
                credit_nxt_s[i] = CW'(CREDIT_MAX);
                sat_hit_s[i]    = 1'b1;
            end else begin
                credit_nxt_s[i] = credit_sum_s[i][CW-1:0];
                sat_hit_s[i]    = 1'b0;
            end
        end
    end

    // State registers; resend needs no special case since it removes all grants
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r             <= NUM_PORT_BITS'(NUM_OUT_PORTS - 1);
            dout_r            <= '0;
            credit_overflow_r <= 1'b0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit_r[i] <= CW'(CREDIT_MAX);
                addr_r[i]   <= '0;
            end
        end else begin
            dout_r            <= pkt_nxt_s;
            credit_overflow_r <= credit_overflow_r | bad_port_s | (|sat_hit_s);
            if (found_s) begin
                ptr_r <= grant_idx_s;
            end else begin
                ptr_r <= ptr_r;
            end
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit_r[i] <= credit_nxt_s[i];
                if (grant_s[i]) begin
                    addr_r[i] <= addr_r[i] + {{(NUM_ADDR_BITS-1){1'b0}}, 1'b1};
                end else begin
                    addr_r[i] <= addr_r[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
module tb_leaf_out_arbiter;

    logic         clk;
    logic         reset_n;
    logic [95:0]  din_s;
    logic [2:0]   vld_s;
    logic [2:0]   ack_s;
    logic [26:0]  dest_cfg_s;
    logic         upd_vld_s;
    logic [3:0]   upd_port_s;
    logic         resend_s;
    logic [48:0]  dout_s;
    logic         ovf_s;

    int           n_checks;
    int           n_errors;
    int           cnum;
    logic [6:0]   exp_addr [3];
    logic [8:0]   dest_tab [3];

    leaf_out_arbiter dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .din_leaf_user2interface (din_s),
        .vld_user2interface      (vld_s),
        .ack_interface2user      (ack_s),
        .dest_cfg                (dest_cfg_s),
        .credit_upd_vld          (upd_vld_s),
        .credit_upd_port         (upd_port_s),
        .resend                  (resend_s),
        .dout_leaf_interface2bft (dout_s),
        .credit_overflow         (ovf_s)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input int p, input int c);
        logic [7:0]  tag8;
        logic [15:0] c16;
        tag8 = 8'hD0 | 8'(p);
        c16  = 16'(c);
        return {tag8, 8'h5A, c16};
    endfunction

    // One clock: drive at posedge+1, check ack at posedge+3, check dout at next posedge+1
    task automatic cyc(input logic [2:0] vld, input logic upd, input logic [3:0] upd_port,
                       input logic rs, input logic [2:0] exp_ack, input string tag);
        logic [48:0] exp_pkt;
        int          gp;
        cnum++;
        for (int p = 0; p < 3; p++) din_s[p*32 +: 32] = data_of(p, cnum);
        vld_s      = vld;
        upd_vld_s  = upd;
        upd_port_s = upd_port;
        resend_s   = rs;
        #2;
        check_val({tag, "_ack"}, 64'(ack_s), 64'(exp_ack));
        exp_pkt = '0;
        gp = -1;
        for (int p = 0; p < 3; p++) if (exp_ack[p]) gp = p;
        if (gp >= 0) begin
            exp_pkt = {1'b1, dest_tab[gp], exp_addr[gp], data_of(gp, cnum)};
            exp_addr[gp] = exp_addr[gp] + 7'd1;
        end
        @(posedge clk);
        #1;
        check_val({tag, "_dout"}, 64'(dout_s), 64'(exp_pkt));
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        vld_s      = 3'b111;
        upd_vld_s  = 1'b1;
        upd_port_s = 4'd5;
        resend_s   = 1'b0;
        #1;
        check_val("rst_dout_async", 64'(dout_s), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_dout", 64'(dout_s), 64'd0);
        check_val("rst_ack", 64'(ack_s), 64'd0);
        check_val("rst_ovf", 64'(ovf_s), 64'd0);
        vld_s     = 3'b000;
        upd_vld_s = 1'b0;
        reset_n   = 1'b1;
        for (int p = 0; p < 3; p++) exp_addr[p] = 7'd0;
    endtask

    initial begin
        clk        = 1'b0;
        reset_n    = 1'b0;
        n_checks   = 0;
        n_errors   = 0;
        cnum       = 0;
        din_s      = '0;
        vld_s      = '0;
        upd_vld_s  = 1'b0;
        upd_port_s = '0;
        resend_s   = 1'b0;
        dest_tab[0] = {5'd3, 4'd1};
        dest_tab[1] = {5'd7, 4'd2};
        dest_tab[2] = {5'd17, 4'd9};
        dest_cfg_s  = {dest_tab[2], dest_tab[1], dest_tab[0]};
        @(posedge clk);
        #1;

        // Reset with active inputs, then round-robin from port 0
        do_reset();
        cyc(3'b111, 1'b0, 4'd0, 1'b0, 3'b001, "rr0");
        cyc(3'b111, 1'b0, 4'd0, 1'b0, 3'b010, "rr1");
        cyc(3'b111, 1'b0, 4'd0, 1'b0, 3'b100, "rr2");
        cyc(3'b111, 1'b0, 4'd0, 1'b0, 3'b001, "rr3");
        cyc(3'b111, 1'b0, 4'd0, 1'b0, 3'b010, "rr4");
        cyc(3'b111, 1'b0, 4'd0, 1'b0, 3'b100, "rr5");
        cyc(3'b000, 1'b0, 4'd0, 1'b0, 3'b000, "idle");
        cyc(3'b101, 1'b0, 4'd0, 1'b0, 3'b001, "skip1");

        // Resend mid-stream: frozen for 4 cycles, then order and addresses continue
        cyc(3'b111, 1'b0, 4'd0, 1'b0, 3'b010, "rs_pre");
        for (int k = 0; k < 4; k++) cyc(3'b111, 1'b0, 4'd0, 1'b1, 3'b000, "rs_on");
        cyc(3'b111, 1'b0, 4'd0, 1'b0, 3'b100, "rs_post0");
        cyc(3'b111, 1'b0, 4'd0, 1'b0, 3'b001, "rs_post1");
        check_val("rr_ovf", 64'(ovf_s), 64'd0);

        // Mid-operation reset, then port 1 alone exhausts its 128 credits
        do_reset();
        for (int k = 0; k < 200; k++)
            cyc(3'b010, 1'b0, 4'd0, 1'b0, (k < 128) ? 3'b010 : 3'b000, "exh");
        cyc(3'b010, 1'b1, 4'd1, 1'b0, 3'b000, "exh_upd");
        for (int k = 0; k < 70; k++)
            cyc(3'b010, 1'b0, 4'd0, 1'b0, (k < 64) ? 3'b010 : 3'b000, "exh_more");
        check_val("exh_ovf", 64'(ovf_s), 64'd0);

        // Port 0 down to credit 10, then send + update gives 73
        for (int k = 0; k < 118; k++) cyc(3'b001, 1'b0, 4'd0, 1'b0, 3'b001, "c10");
        cyc(3'b001, 1'b1, 4'd0, 1'b0, 3'b001, "simul");
        for (int k = 0; k < 76; k++)
            cyc(3'b001, 1'b0, 4'd0, 1'b0, (k < 73) ? 3'b001 : 3'b000, "c73");
        check_val("simul_ovf", 64'(ovf_s), 64'd0);

        // Overflow on a full port: saturates at 128, flag sticky
        cyc(3'b000, 1'b1, 4'd2, 1'b0, 3'b000, "ovf_upd");
        check_val("ovf_set", 64'(ovf_s), 64'd1);
        for (int k = 0; k < 131; k++)
            cyc(3'b100, 1'b0, 4'd0, 1'b0, (k < 128) ? 3'b100 : 3'b000, "sat");
        check_val("ovf_sticky", 64'(ovf_s), 64'd1);

        // Out-of-range update port
        do_reset();
        cyc(3'b000, 1'b0, 4'd5, 1'b0, 3'b000, "badp_idle");
        check_val("badp_pre", 64'(ovf_s), 64'd0);
        cyc(3'b000, 1'b1, 4'd5, 1'b0, 3'b000, "badp");
        check_val("badp_ovf", 64'(ovf_s), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
